// File: rtl/digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_mux
// Purpose  : Time-multiplexed 4-digit scanner. Double-buffers a 12-bit frame
//            and drives one 3-bit digit code plus its active-low enable per slot.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_mux #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  output logic        load_ready,
  input  logic        blank,
  output logic [2:0]  ABC,
  output logic [3:0]  AN,
  output logic [1:0]  scan_idx
);

  localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                 r_state;
  logic [c_presc_w-1:0]   r_presc;
  logic [11:0]            r_active;
  logic [11:0]            r_pending;
  logic                   r_pend_flag;

  logic                   w_tick;
  logic                   w_accept;
  logic                   w_xfer;
  logic [11:0]            w_active_nxt;
  state_t                 w_state_nxt;
  logic [1:0]             w_idx_nxt;
  logic [2:0]             w_digit;
  logic [3:0]             w_an_nxt;

  assign w_tick     = (r_presc == c_presc_last);
  assign load_ready = ~r_pend_flag;
  // Accept and transfer are mutually exclusive: one needs the flag clear,
  // the other needs it set, so a load on a tick waits one full slot.
  assign w_accept   = load_valid & ~r_pend_flag;
  assign w_xfer     = w_tick & r_pend_flag;
  assign w_active_nxt = w_xfer ? r_pending : r_active;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = scan_idx;
    if (r_state == IDLE) begin
      if (w_xfer) begin
        w_state_nxt = SCAN;
        w_idx_nxt   = 2'd0;
      end
    end else begin
      w_idx_nxt = scan_idx + 2'd1;
    end
  end

  // Digit comes from the post-transfer frame so a new frame shows in its landing slot.
  always_comb begin
    w_digit = 3'b000;
    case (w_idx_nxt)
      2'd0: w_digit = w_active_nxt[2:0];
      2'd1: w_digit = w_active_nxt[5:3];
      2'd2: w_digit = w_active_nxt[8:6];
      2'd3: w_digit = w_active_nxt[11:9];
      default: w_digit = 3'b000;
    endcase
  end

  always_comb begin
    w_an_nxt = 4'b1111;
    if ((w_state_nxt == SCAN) && !blank) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_state     <= IDLE;
      r_active    <= 12'd0;
      r_pending   <= 12'd0;
      r_pend_flag <= 1'b0;
      scan_idx    <= 2'd0;
      ABC         <= 3'b000;
      AN          <= 4'b1111;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      if (w_accept) begin
        r_pending <= load_data;
      end

      if (w_xfer) begin
        r_active    <= r_pending;
        r_pend_flag <= 1'b0;
      end else if (w_accept) begin
        r_pend_flag <= 1'b1;
      end

      if (w_tick) begin
        r_state  <= w_state_nxt;
        scan_idx <= w_idx_nxt;
        ABC      <= w_digit;
        AN       <= w_an_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_mux
// Purpose  : Directed, table-driven bench for digit_scan_mux at CLK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_ready;
  logic        blank;
  logic [2:0]  ABC;
  logic [3:0]  AN;
  logic [1:0]  scan_idx;

  int n_checks = 0;
  int n_fail   = 0;

  digit_scan_mux #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank      (blank),
    .ABC        (ABC),
    .AN         (AN),
    .scan_idx   (scan_idx)
  );

  always #5 clk = ~clk;

  // Each record: held for n cycles; expectations are checked at every falling
  // edge before that cycle's inputs are driven.
  typedef struct {
    int          n;
    logic        lv;
    logic [11:0] ld;
    logic        bl;
    logic        rdy;
    logic [2:0]  abc;
    logic [3:0]  an;
    logic [1:0]  idx;
  } vec_t;

  vec_t tbl[40];
  int   ntbl = 0;

  task automatic add(input int n, input logic lv, input logic [11:0] ld, input logic bl,
                     input logic rdy, input logic [2:0] abc, input logic [3:0] an,
                     input logic [1:0] idx);
    tbl[ntbl].n   = n;
    tbl[ntbl].lv  = lv;
    tbl[ntbl].ld  = ld;
    tbl[ntbl].bl  = bl;
    tbl[ntbl].rdy = rdy;
    tbl[ntbl].abc = abc;
    tbl[ntbl].an  = an;
    tbl[ntbl].idx = idx;
    ntbl++;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [2:0] abc,
                         input logic [3:0] an, input logic [1:0] idx);
    chk({tag, " load_ready"}, {11'd0, load_ready}, {11'd0, rdy});
    chk({tag, " ABC"},        {9'd0, ABC},         {9'd0, abc});
    chk({tag, " AN"},         {8'd0, AN},          {8'd0, an});
    chk({tag, " scan_idx"},   {10'd0, scan_idx},   {10'd0, idx});
  endtask

  task automatic run_tbl(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        @(negedge clk);
        chk_all($sformatf("vec%0d.%0d", i, c), tbl[i].rdy, tbl[i].abc, tbl[i].an, tbl[i].idx);
        load_valid = tbl[i].lv;
        load_data  = tbl[i].ld;
        blank      = tbl[i].bl;
      end
    end
  endtask

  int part_a_last;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 12'd0;
    blank      = 1'b0;

    // Idle after reset, then frame 7531 through a full wrap.
    add(8, 1'b0, 12'o0,    1'b0, 1'b1, 3'd0, 4'b1111, 2'd0);
    add(1, 1'b1, 12'o7531, 1'b0, 1'b1, 3'd0, 4'b1111, 2'd0);
    add(2, 1'b0, 12'o0,    1'b0, 1'b0, 3'd0, 4'b1111, 2'd0);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd1, 4'b1110, 2'd0);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd3, 4'b1101, 2'd1);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd5, 4'b1011, 2'd2);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd7, 4'b0111, 2'd3);
    // Wrap slot: accept 0246 on its first cycle, then hold 1111 while not ready.
    add(1, 1'b1, 12'o0246, 1'b0, 1'b1, 3'd1, 4'b1110, 2'd0);
    add(3, 1'b1, 12'o1111, 1'b0, 1'b0, 3'd1, 4'b1110, 2'd0);
    add(1, 1'b1, 12'o1111, 1'b0, 1'b1, 3'd4, 4'b1101, 2'd1);
    add(3, 1'b0, 12'o0,    1'b0, 1'b0, 3'd4, 4'b1101, 2'd1);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd1, 4'b1011, 2'd2);
    // Blank across two ticks, then a short blank pulse between ticks.
    add(4, 1'b0, 12'o0,    1'b1, 1'b1, 3'd1, 4'b0111, 2'd3);
    add(4, 1'b0, 12'o0,    1'b1, 1'b1, 3'd1, 4'b1111, 2'd0);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd1, 4'b1111, 2'd1);
    add(1, 1'b0, 12'o0,    1'b1, 1'b1, 3'd1, 4'b1011, 2'd2);
    add(3, 1'b0, 12'o0,    1'b0, 1'b1, 3'd1, 4'b1011, 2'd2);
    add(1, 1'b0, 12'o0,    1'b0, 1'b1, 3'd1, 4'b0111, 2'd3);
    part_a_last = ntbl - 1;
    // After mid-scan reset: idle, then a load offered exactly on the tick cycle.
    add(2, 1'b0, 12'o0,    1'b0, 1'b1, 3'd0, 4'b1111, 2'd0);
    add(1, 1'b1, 12'o1234, 1'b0, 1'b1, 3'd0, 4'b1111, 2'd0);
    add(4, 1'b0, 12'o0,    1'b0, 1'b0, 3'd0, 4'b1111, 2'd0);
    add(4, 1'b0, 12'o0,    1'b0, 1'b1, 3'd4, 4'b1110, 2'd0);
    add(1, 1'b0, 12'o0,    1'b0, 1'b1, 3'd3, 4'b1101, 2'd1);

    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 1'b1, 3'd0, 4'b1111, 2'd0);
    rst = 1'b0;

    run_tbl(0, part_a_last);

    // Set the pending flag with a frame that must never be shown.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 12'o6666;
    @(negedge clk);
    load_valid = 1'b0;
    chk_all("flag_set", 1'b0, 3'd1, 4'b0111, 2'd3);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 1'b1, 3'd0, 4'b1111, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk_all("reset_held", 1'b1, 3'd0, 4'b1111, 2'd0);
    rst = 1'b0;

    run_tbl(part_a_last + 1, ntbl - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clock cycles per digit slot; legal range 2..65536.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load_valid  input  1  the upstream offers a new 4-digit frame.
REQ-005 SHALL have port load_data  input  12  the frame: digit k occupies bits [3k+2:3k], k=0..3.
REQ-006 SHALL have port load_ready  output  1  the block can accept a frame this cycle.
REQ-007 SHALL have port blank  input  1  forces all digit enables off while high.
REQ-008 SHALL have port ABC  output  3  the selected digit code, fed directly to the 7-segment decoder input ABC.
REQ-009 SHALL have port AN  output  4  active-low digit enables, one-hot-low when displaying.
REQ-010 SHALL have port scan_idx  output  2  the index of the digit currently driven.

Function
REQ-011 SHALL run a prescaler counting 0..CLK_DIV-1, then wrapping to 0; "tick" = the cycle in which prescaler == CLK_DIV-1.
REQ-012 SHALL run the prescaler continuously out of reset, in every state, independent of blank and of the handshake.
REQ-013 SHALL hold a 12-bit active register, a 12-bit pending register and a pending flag.
REQ-014 SHALL drive load_ready = NOT pending flag, combinationally from the registered flag.
REQ-015 SHALL accept a frame on a cycle with load_valid=1 and load_ready=1: load_data goes to pending, and the flag sets at that edge.
REQ-016 SHALL ignore load_data when load_ready=0; a held load_valid is accepted on the first cycle load_ready returns to 1.
REQ-017 SHALL, on a tick with the flag set, copy pending to active and clear the flag at that edge.
REQ-018 SHALL, when accept and tick coincide with the flag clear, capture the frame into pending only; transfer to active occurs at the following tick (CLK_DIV cycles later).
REQ-019 SHALL implement states IDLE (after reset, nothing displayed) and SCAN.
REQ-020 SHALL transition IDLE->SCAN on the first tick that transfers pending to active, setting scan_idx=0 at that edge; there is no SCAN->IDLE transition except reset.
REQ-021 SHALL, in SCAN on each tick, advance scan_idx by 1 modulo 4 (3 wraps to 0); the transfer tick that enters SCAN is excluded.
REQ-022 SHALL register ABC, AN and scan_idx, all updating at the same tick edge; between ticks they are stable.
REQ-023 SHALL set ABC at each tick edge to the digit of the post-transfer active register selected by the new scan_idx, so a new frame is visible in the same slot it lands.
REQ-024 SHALL set AN at each tick edge to all-ones (4'b1111) when in IDLE or when blank=1 that cycle; otherwise AN bit scan_idx=0 and all other bits=1.
REQ-025 SHALL sample blank only on tick cycles; a blank pulse not spanning a tick has no effect.
REQ-026 SHALL keep ABC valid (the selected digit) while blanked; only AN is forced.
REQ-027 SHALL size the prescaler to clog2(CLK_DIV) bits, with no overflow or reachable unused count.

Reset
REQ-028 SHALL, while rst=1, force the following regardless of clk: prescaler=0, state=IDLE, scan_idx=0, ABC=3'b000, AN=4'b1111, active=0, pending=0, flag=0, load_ready=1.
REQ-029 SHALL discard any pending frame and restart in IDLE when reset asserts mid-scan; the first tick comes CLK_DIV cycles after the first rising edge with rst=0.

Verification (CLK_DIV=4 unless stated)
REQ-030 SHALL cover this scenario: assert reset, then release with no load -> AN=1111, ABC=000 and load_ready=1 indefinitely; prescaler ticks every 4 cycles.
REQ-031 SHALL cover this scenario: accept load_data=12'o7531 (d0=1,d1=3,d2=5,d3=7) -> at the next tick state=SCAN, scan_idx=0, ABC=001, AN=1110; on later ticks ABC=011/AN=1101, then ABC=101/AN=1011, then ABC=111/AN=0111, then wrap to ABC=001/AN=1110.
REQ-032 SHALL cover this scenario: while scanning, accept frame 12'o0246, then hold load_valid with 12'o1111 -> load_ready=0 until the next tick; the second frame is accepted the cycle after that tick; digits show 0246 values from the transfer slot on, then 1111 after the subsequent tick.
REQ-033 SHALL cover this scenario: accept a load exactly on a tick cycle from IDLE -> no display change at that tick; SCAN entered 4 cycles later with scan_idx=0.
REQ-034 SHALL cover this scenario: blank=1 held across two ticks during SCAN -> AN=1111 for those slots while ABC and scan_idx keep advancing; AN resumes one-hot at the first tick after blank=0.
REQ-035 SHALL cover this scenario: assert rst asynchronously mid-slot with the flag set -> outputs reach reset values before the next clk edge, load_ready=1, and the pending frame is never displayed.
